// File: rtl/cat_recognizer_pkg.sv
// Shared definitions for the cat_recognizer APB front end:
// control address, status bit positions and the APB access-phase states.
package cat_recognizer_pkg;
  localparam int CTRL_ADDR   = 0;
  localparam int STAT_BUSY   = 1;
  localparam int STAT_DONE   = 2;
  localparam int STAT_RESULT = 3;
  localparam int STAT_ERR    = 4;
  localparam int STAT_OVR    = 5;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} apb_state_t;
endpackage

// File: rtl/apb_access_tracker.sv
// Follows the APB phase sequence and emits one commit pulse per access,
// plus a protocol-error pulse when an access phase appears with no setup.
module apb_access_tracker
  import cat_recognizer_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic psel,
  input  logic penable,
  output logic commit,
  output logic perr
);

  apb_state_t state_q, state_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // commit fires on the edge that enters ACCESS, so the bus address and
  // data are still those of the transfer being committed
  always_comb begin
    state_d = state_q;
    commit  = 1'b0;
    perr    = 1'b0;
    case (state_q)
      IDLE: begin
        if (psel && penable) begin
          perr    = 1'b1;
          state_d = HOLD;
        end else if (psel) begin
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (!psel) state_d = IDLE;
        else if (penable) begin
          commit  = 1'b1;
          state_d = ACCESS;
        end
      end
      ACCESS, HOLD: begin
        if (!psel)        state_d = IDLE;
        else if (penable) state_d = HOLD;
        else              state_d = SETUP;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/apb_image_loader.sv
// APB slave front end of cat_recognizer: streams image words into the image
// memory, issues start to the core and latches its done/result status.
module apb_image_loader
  import cat_recognizer_pkg::*;
#(
  parameter int Amba_Word       = 24,
  parameter int Amba_Addr_Depth = 13,
  parameter int file_length     = 4096
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       PSEL,
  input  logic                       PENABLE,
  input  logic                       PWRITE,
  input  logic [Amba_Addr_Depth-1:0] PADDR,
  input  logic [Amba_Word-1:0]       PWDATA,
  output logic [Amba_Word-1:0]       PRDATA,
  output logic                       mem_we,
  output logic [Amba_Addr_Depth-1:0] mem_addr,
  output logic [Amba_Word-1:0]       mem_wdata,
  output logic                       start,
  input  logic                       core_done,
  input  logic                       core_result
);

  localparam logic [Amba_Addr_Depth-1:0] CTRL   = Amba_Addr_Depth'(CTRL_ADDR);
  localparam logic [Amba_Addr_Depth-1:0] LAST   = Amba_Addr_Depth'(file_length);
  localparam logic [Amba_Addr_Depth-1:0] CNT_AD = Amba_Addr_Depth'(file_length + 1);
  localparam logic [Amba_Addr_Depth-1:0] ONE    = Amba_Addr_Depth'(1);

  logic commit, perr;

  apb_access_tracker u_trk (
    .clk     (clk),
    .rst     (rst),
    .psel    (PSEL),
    .penable (PENABLE),
    .commit  (commit),
    .perr    (perr)
  );

  logic                       busy_q, busy_d, done_q, done_d, result_q, result_d;
  logic                       err_q, err_d, ovr_q, ovr_d;
  logic                       mem_we_q, mem_we_d, start_q, start_d;
  logic [Amba_Addr_Depth-1:0] word_cnt_q, word_cnt_d, mem_addr_q, mem_addr_d;
  logic [Amba_Word-1:0]       mem_wdata_q, mem_wdata_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= 1'b0;
      err_q       <= 1'b0;
      ovr_q       <= 1'b0;
      mem_we_q    <= 1'b0;
      start_q     <= 1'b0;
      word_cnt_q  <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      busy_q      <= busy_d;
      done_q      <= done_d;
      result_q    <= result_d;
      err_q       <= err_d;
      ovr_q       <= ovr_d;
      mem_we_q    <= mem_we_d;
      start_q     <= start_d;
      word_cnt_q  <= word_cnt_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  always_comb begin
    busy_d      = busy_q;
    done_d      = done_q;
    result_d    = result_q;
    err_d       = err_q;
    ovr_d       = ovr_q;
    word_cnt_d  = word_cnt_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    start_d     = 1'b0;
    if (commit && PWRITE) begin
      if (PADDR == CTRL) begin
        if (PWDATA[0]) begin
          if (busy_q) ovr_d = 1'b1;
          else begin
            start_d    = 1'b1;
            busy_d     = 1'b1;
            done_d     = 1'b0;
            word_cnt_d = '0;
          end
        end else begin
          err_d = 1'b0;
          ovr_d = 1'b0;
        end
      end else if (PADDR <= LAST) begin
        if (busy_q) ovr_d = 1'b1;
        else begin
          mem_we_d    = 1'b1;
          mem_addr_d  = PADDR - ONE;
          mem_wdata_d = PWDATA;
          if (word_cnt_q != LAST) word_cnt_d = word_cnt_q + ONE;
        end
      end else begin
        err_d = 1'b1;
      end
    end
    if (perr) err_d = 1'b1;
    // busy_q gates both start and done, so a start colliding with done is
    // already rejected above and flagged as overrun
    if (core_done && busy_q) begin
      busy_d   = 1'b0;
      done_d   = 1'b1;
      result_d = core_result;
    end
  end

  always_comb begin
    PRDATA = '0;
    if (PSEL && !PWRITE) begin
      if (PADDR == CTRL) begin
        PRDATA[STAT_BUSY]   = busy_q;
        PRDATA[STAT_DONE]   = done_q;
        PRDATA[STAT_RESULT] = result_q;
        PRDATA[STAT_ERR]    = err_q;
        PRDATA[STAT_OVR]    = ovr_q;
      end else if (PADDR == CNT_AD) begin
        PRDATA = Amba_Word'(word_cnt_q);
      end
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign start     = start_q;

endmodule

// File: tb/tb_apb_image_loader.sv
// Scoreboard bench for apb_image_loader: stimulus pushes expected memory
// writes, start pulses and read data; a negedge monitor pops and compares.
module tb_apb_image_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [12:0] PADDR = '0;
  logic [23:0] PWDATA = '0;
  logic [23:0] PRDATA;
  logic        mem_we, start;
  logic [12:0] mem_addr;
  logic [23:0] mem_wdata;
  logic        core_done = 1'b0, core_result = 1'b0;

  apb_image_loader #(.Amba_Word(24), .Amba_Addr_Depth(13), .file_length(4096)) dut (
    .clk(clk), .rst(rst), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .start(start),
    .core_done(core_done), .core_result(core_result)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [12:0] a; logic [23:0] d;} mw_t;
  mw_t         mq[$];
  int          sq[$];
  logic [23:0] rq[$];
  int          checks = 0, errors = 0;
  int          mem_seen = 0, start_seen = 0;
  mw_t         e_mw;
  logic [23:0] e_rd;

  always @(negedge clk) begin
    if (mem_we) begin
      mem_seen++;
      checks++;
      if (mq.size() == 0) begin
        errors++;
        $display("FAIL mem_we_unexpected: got addr=%0d data=%h, required no write", mem_addr, mem_wdata);
      end else begin
        e_mw = mq.pop_front();
        if (mem_addr !== e_mw.a || mem_wdata !== e_mw.d) begin
          errors++;
          $display("FAIL mem_write: got addr=%0d data=%h, required addr=%0d data=%h",
                   mem_addr, mem_wdata, e_mw.a, e_mw.d);
        end
      end
    end
    if (start) begin
      start_seen++;
      checks++;
      if (sq.size() == 0) begin
        errors++;
        $display("FAIL start_unexpected: got start=1, required 0");
      end else void'(sq.pop_front());
    end
    if (PSEL && PENABLE && !PWRITE) begin
      checks++;
      if (rq.size() == 0) begin
        errors++;
        $display("FAIL read_unexpected: addr=%0d got %h", PADDR, PRDATA);
      end else begin
        e_rd = rq.pop_front();
        if (PRDATA !== e_rd) begin
          errors++;
          $display("FAIL prdata addr=%0d: got %h, required %h", PADDR, PRDATA, e_rd);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    cyc(); PSEL = 0; PENABLE = 0; PWRITE = 0; core_done = 0;
  endtask

  task automatic apb_write(input logic [12:0] a, input logic [23:0] d,
                           input logic cd = 1'b0, input logic cr = 1'b0);
    cyc(); PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = a; PWDATA = d; core_done = 0;
    cyc(); PENABLE = 1; core_done = cd; core_result = cr;
  endtask

  task automatic apb_read(input logic [12:0] a, input logic [23:0] exp);
    rq.push_back(exp);
    cyc(); PSEL = 1; PENABLE = 0; PWRITE = 0; PADDR = a; core_done = 0;
    cyc(); PENABLE = 1;
  endtask

  task automatic img_write(input logic [12:0] a, input logic [23:0] d);
    mq.push_back(mw_t'{a: a - 13'd1, d: d});
    apb_write(a, d);
  endtask

  task automatic pulse_done(input logic r);
    cyc(); PSEL = 0; PENABLE = 0; core_done = 1; core_result = r;
    cyc(); core_done = 0;
  endtask

  function automatic logic [63:0] outs();
    return {3'b0, PRDATA, mem_we, mem_addr, mem_wdata, start};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", outs(), 64'd0);
    cyc(); rst = 0;

    // 1: fill the image memory back-to-back
    apb_write(13'd0, 24'd0);
    for (int i = 1; i <= 4096; i++) img_write(13'(i), 24'h010203 + 24'(i));
    idle();
    apb_read(13'd4097, 24'd4096);
    apb_read(13'd0, 24'h00);
    apb_read(13'd100, 24'h00);

    // 2: start, then done with cat result
    sq.push_back(1);
    apb_write(13'd0, 24'd1);
    @(negedge clk);
    check("prdata_during_write", 64'(PRDATA), 64'd0);
    idle();
    apb_read(13'd0, 24'h02);
    apb_read(13'd4097, 24'd0);
    pulse_done(1'b1);
    apb_read(13'd0, 24'h0C);

    // 3: writes while busy are dropped and flagged as overrun
    sq.push_back(1);
    apb_write(13'd0, 24'd1);
    apb_read(13'd0, 24'h0A);
    apb_write(13'd5, 24'h123456);
    apb_write(13'd0, 24'd1);
    apb_read(13'd0, 24'h2A);
    apb_write(13'd0, 24'd0);
    apb_read(13'd0, 24'h0A);
    apb_read(13'd4097, 24'd0);
    pulse_done(1'b0);
    apb_read(13'd0, 24'h04);

    // 4: out-of-range address, held access, protocol error
    apb_write(13'd4097, 24'h777777);
    apb_read(13'd0, 24'h14);
    img_write(13'd3, 24'hABCDEF);
    repeat (4) cyc();
    idle();
    apb_read(13'd4097, 24'd1);
    apb_write(13'd0, 24'd0);
    apb_read(13'd0, 24'h04);
    idle();
    cyc(); PSEL = 1; PENABLE = 1; PWRITE = 1; PADDR = 13'd9; PWDATA = 24'h999999;
    idle();
    apb_read(13'd0, 24'h14);
    apb_write(13'd0, 24'd0);
    apb_read(13'd0, 24'h04);

    // 5: core_done in the cycle of a start commit
    sq.push_back(1);
    apb_write(13'd0, 24'd1);
    apb_read(13'd0, 24'h02);
    apb_write(13'd0, 24'd1, 1'b1, 1'b1);
    idle();
    apb_read(13'd0, 24'h2C);
    apb_write(13'd0, 24'd0);
    apb_read(13'd0, 24'h0C);

    // 6: reset during the access phase of a write to addr 7
    idle();
    cyc(); PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = 13'd7; PWDATA = 24'h070707;
    cyc(); PENABLE = 1; rst = 1;
    @(negedge clk);
    check("outputs_in_reset", outs(), 64'd0);
    idle();
    cyc(); rst = 0;
    repeat (3) cyc();
    @(negedge clk);
    check("outputs_after_reset", outs(), 64'd0);
    apb_read(13'd0, 24'h00);
    apb_read(13'd4097, 24'd0);
    idle();
    repeat (3) cyc();

    check("mem_we_count", 64'(mem_seen), 64'd4097);
    check("start_count", 64'(start_seen), 64'd3);
    check("mem_queue_left", 64'(mq.size()), 64'd0);
    check("start_queue_left", 64'(sq.size()), 64'd0);
    check("read_queue_left", 64'(rq.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
